// File: rtl/perceptron_seq_if.sv
// Sample, weight-write and result bundle for perceptron_seq.
// The master drives samples and weight writes; the slave (the perceptron) returns results.
interface perceptron_seq_if #(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned W_W   = 4,
  parameter int unsigned ACC_W = 8
);
  logic [N_IN-1:0]         x;
  logic                    target;
  logic                    train;
  logic                    in_valid;
  logic                    in_ready;
  logic                    w_wr_en;
  logic [3:0]              w_wr_idx;
  logic signed [W_W-1:0]   w_wr_data;
  logic                    y;
  logic signed [ACC_W-1:0] score;
  logic                    out_valid;
  logic                    updated;

  modport master (
    output x, target, train, in_valid, w_wr_en, w_wr_idx, w_wr_data,
    input  in_ready, y, score, out_valid, updated
  );

  modport slave (
    input  x, target, train, in_valid, w_wr_en, w_wr_idx, w_wr_data,
    output in_ready, y, score, out_valid, updated
  );
endinterface

// File: rtl/perceptron_seq.sv
// Sequential perceptron: one multiply-accumulate step per cycle over N_IN binary features,
// signed weights plus bias. Define PERCEPTRON_TRAIN_EN to compile in online training with the
// perceptron rule (saturating +/-1 steps); without it, weights change only via direct writes.
module perceptron_seq #(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned W_W   = 4,
  parameter int unsigned ACC_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  perceptron_seq_if.slave  bus_io
);

  localparam int unsigned IdxW = 4;
  localparam logic [IdxW-1:0] LastX   = IdxW'(N_IN - 1);
  localparam logic [IdxW-1:0] BiasIdx = IdxW'(N_IN);

  typedef enum logic [1:0] {StIdle, StAcc, StDecide, StUpdate} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_IN-1:0]         x_q, x_d;
  logic                    y_q, y_d;
  logic signed [ACC_W-1:0] score_q, score_d;
  logic signed [W_W-1:0]   w_q [N_IN+1];

  logic signed [W_W-1:0]   w_sel;
  logic                    x_bit;
  logic signed [W_W-1:0]   bias_eff;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    wr_hit;

  // Writes only land while idle and for an index that exists (bias included).
  assign wr_hit = (state_q == StIdle) && bus_io.w_wr_en && (bus_io.w_wr_idx <= BiasIdx);

  // A bias write on the accepting edge seeds the accumulator with the new value.
  assign bias_eff = (wr_hit && (bus_io.w_wr_idx == BiasIdx)) ? bus_io.w_wr_data : w_q[N_IN];

`ifdef PERCEPTRON_TRAIN_EN
  logic                    target_q, target_d;
  logic                    train_q, train_d;
  logic [N_IN:0]           upd_mask;

  // Bias always steps; a feature weight steps only when its input bit was set.
  assign upd_mask = {1'b1, x_q};

  function automatic logic signed [W_W-1:0] sat_step(input logic signed [W_W-1:0] w,
                                                     input logic up);
    logic signed [W_W-1:0] w_max, w_min, one;
    w_max = {1'b0, {(W_W-1){1'b1}}};
    w_min = {1'b1, {(W_W-1){1'b0}}};
    one   = W_W'(1);
    if (up) return (w == w_max) ? w : w + one;
    else    return (w == w_min) ? w : w - one;
  endfunction
`else
  logic unused_train;
  assign unused_train = bus_io.train ^ bus_io.target;
`endif

  // Select the weight and feature bit addressed by the running index.
  always_comb begin
    w_sel = '0;
    x_bit = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (idx_q == IdxW'(i)) begin
        w_sel = w_q[i];
        x_bit = x_q[i];
      end
    end
  end

  assign acc_sum = acc_q + (x_bit ? {{(ACC_W-W_W){w_sel[W_W-1]}}, w_sel} : '0);

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    score_d  = score_q;
`ifdef PERCEPTRON_TRAIN_EN
    target_d = target_q;
    train_d  = train_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          x_d      = bus_io.x;
`ifdef PERCEPTRON_TRAIN_EN
          target_d = bus_io.target;
          train_d  = bus_io.train;
`endif
          acc_d    = {{(ACC_W-W_W){bias_eff[W_W-1]}}, bias_eff};
          idx_d    = '0;
          state_d  = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_sum;
        idx_d = idx_q + IdxW'(1);
        // Result registers load on the last step so they are valid during DECIDE.
        if (idx_q == LastX) begin
          y_d     = ~acc_sum[ACC_W-1];
          score_d = acc_sum;
          state_d = StDecide;
        end
      end
      StDecide: begin
        idx_d   = '0;
        state_d = StIdle;
`ifdef PERCEPTRON_TRAIN_EN
        if (train_q && (y_q != target_q)) state_d = StUpdate;
`endif
      end
`ifdef PERCEPTRON_TRAIN_EN
      StUpdate: begin
        idx_d = idx_q + IdxW'(1);
        if (idx_q == BiasIdx) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Control and result state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= 1'b0;
      score_q  <= '0;
`ifdef PERCEPTRON_TRAIN_EN
      target_q <= 1'b0;
      train_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      score_q  <= score_d;
`ifdef PERCEPTRON_TRAIN_EN
      target_q <= target_d;
      train_q  <= train_d;
`endif
    end
  end

  // Weight/bias storage: direct writes in idle, training steps one register per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= N_IN; i++) w_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i <= N_IN; i++) begin
        if (wr_hit && (bus_io.w_wr_idx == IdxW'(i))) w_q[i] <= bus_io.w_wr_data;
`ifdef PERCEPTRON_TRAIN_EN
        if ((state_q == StUpdate) && (idx_q == IdxW'(i)) && upd_mask[i]) begin
          w_q[i] <= sat_step(w_q[i], target_q);
        end
`endif
      end
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.y         = y_q;
  assign bus_io.score     = score_q;
  assign bus_io.out_valid = (state_q == StDecide);
`ifdef PERCEPTRON_TRAIN_EN
  assign bus_io.updated   = (state_q == StUpdate) && (idx_q == BiasIdx);
`else
  assign bus_io.updated   = 1'b0;
`endif

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq (N_IN=7, W_W=4, ACC_W=8). Covers the training path when
// PERCEPTRON_TRAIN_EN is defined and the train-ignored behaviour otherwise.
module tb_perceptron_seq;
  localparam int unsigned N_IN  = 7;
  localparam int unsigned W_W   = 4;
  localparam int unsigned ACC_W = 8;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  perceptron_seq_if #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W)) bus ();

  perceptron_seq #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic signed [3:0] dat);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_idx  = idx;
    bus.w_wr_data = dat;
    @(posedge clk); #1;
    bus.w_wr_en   = 1'b0;
  endtask

  // One sample from IDLE to IDLE. sw_* is a write on the accepting edge, bw_* a write held
  // for the whole busy period. Cycle numbers are relative to the accepting edge T0.
  task automatic run(input string tag, input logic [6:0] xv, input logic tgt, input logic trn,
                     input logic sw_en, input logic [3:0] sw_idx, input logic signed [3:0] sw_dat,
                     input logic bw_en, input logic [3:0] bw_idx, input logic signed [3:0] bw_dat,
                     input int exp_score, input logic exp_y, input int exp_upd, input int exp_rdy);
    int ov, upd, rdy;
    logic signed [7:0] sc;
    logic yy;
    ov = 0; upd = 0; rdy = 0; sc = '0; yy = 1'b0;
    bus.x         = xv;
    bus.target    = tgt;
    bus.train     = trn;
    bus.in_valid  = 1'b1;
    bus.w_wr_en   = sw_en;
    bus.w_wr_idx  = sw_idx;
    bus.w_wr_data = sw_dat;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.w_wr_en   = bw_en;
    bus.w_wr_idx  = bw_idx;
    bus.w_wr_data = bw_dat;
    for (int c = 1; c <= 60; c++) begin
      if (bus.out_valid && ov == 0) begin
        ov = c;
        sc = bus.score;
        yy = bus.y;
      end
      if (bus.updated && upd == 0) upd = c;
      if (bus.in_ready) begin
        rdy = c;
        break;
      end
      @(posedge clk); #1;
    end
    bus.w_wr_en = 1'b0;
    check({tag, " out_valid cycle"}, ov, N_IN + 1);
    check({tag, " score"}, sc, exp_score);
    check({tag, " y"}, yy, exp_y);
    check({tag, " updated cycle"}, upd, exp_upd);
    check({tag, " in_ready cycle"}, rdy, exp_rdy);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.x         = '0;
    bus.target    = 1'b0;
    bus.train     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.w_wr_en   = 1'b0;
    bus.w_wr_idx  = '0;
    bus.w_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", bus.in_ready, 1);
    check("reset y", bus.y, 0);
    check("reset score", bus.score, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset updated", bus.updated, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic inference: w0=3, w1=-5, bias=1.
    wr(4'd0, 4'sd3);
    wr(4'd1, -4'sd5);
    wr(4'd7, 4'sd1);
    run("infer x=3", 7'b0000011, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        -1, 1'b0, 0, N_IN + 2);
    run("infer x=1", 7'b0000001, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        4, 1'b1, 0, N_IN + 2);

    // Reset in the middle of accumulation.
    bus.x        = 7'b0000011;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midreset in_ready", bus.in_ready, 1);
    check("midreset y", bus.y, 0);
    check("midreset score", bus.score, 0);
    check("midreset out_valid", bus.out_valid, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midreset out_valid hold", bus.out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("post-reset x=1", 7'b0000001, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        0, 1'b1, 0, N_IN + 2);
    run("post-reset x=all", 7'b1111111, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        0, 1'b1, 0, N_IN + 2);

    // Writes held throughout ACC are ignored.
    wr(4'd0, 4'sd3);
    wr(4'd1, -4'sd5);
    wr(4'd7, 4'sd1);
    run("busy acc write", 7'b0000011, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b1, 4'd0, 4'sd7,
        -1, 1'b0, 0, N_IN + 2);
    run("after busy acc", 7'b0000011, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        -1, 1'b0, 0, N_IN + 2);

`ifdef PERCEPTRON_TRAIN_EN
    // Misclassified training sample; a bias write held across ACC/UPDATE must be dropped.
    run("train x=3", 7'b0000011, 1'b1, 1'b1, 1'b0, 4'd0, 4'sd0, 1'b1, 4'd7, -4'sd3,
        -1, 1'b0, 2 * N_IN + 2, 2 * N_IN + 3);
    run("retrain x=3", 7'b0000011, 1'b1, 1'b1, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        2, 1'b1, 0, N_IN + 2);
    run("trained bias only", 7'b1111100, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        2, 1'b1, 0, N_IN + 2);
    run("trained w0", 7'b0000001, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        6, 1'b1, 0, N_IN + 2);

    // Upward saturation: w0 and bias at +7 must not wrap.
    for (int r = 0; r < 2; r++) begin
      wr(4'd0, 4'sd7);
      wr(4'd7, 4'sd7);
      wr(4'd1, -4'sd8);
      wr(4'd2, -4'sd8);
      run("sat up train", 7'b0000111, 1'b1, 1'b1, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
          -2, 1'b0, 2 * N_IN + 2, 2 * N_IN + 3);
      run("sat up check", 7'b0000001, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
          14, 1'b1, 0, N_IN + 2);
    end

    // Downward saturation: w0 and bias at -8 stay -8; w1..w3 step 7 -> 6.
    wr(4'd0, -4'sd8);
    wr(4'd7, -4'sd8);
    wr(4'd1, 4'sd7);
    wr(4'd2, 4'sd7);
    wr(4'd3, 4'sd7);
    run("sat down train", 7'b0001111, 1'b0, 1'b1, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        5, 1'b1, 2 * N_IN + 2, 2 * N_IN + 3);
    run("sat down w0", 7'b0000001, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        -16, 1'b0, 0, N_IN + 2);
    run("sat down w1-3", 7'b0001110, 1'b0, 1'b0, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        10, 1'b1, 0, N_IN + 2);
`else
    // Training compiled out: misclassified sample with train=1 leaves weights alone.
    run("notrain x=3", 7'b0000011, 1'b1, 1'b1, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        -1, 1'b0, 0, N_IN + 2);
    run("notrain rerun", 7'b0000011, 1'b1, 1'b1, 1'b0, 4'd0, 4'sd0, 1'b0, 4'd0, 4'sd0,
        -1, 1'b0, 0, N_IN + 2);
`endif

    // Write on the accepting edge is used by that same sample.
    wr(4'd0, -4'sd2);
    run("same-edge bias", 7'b0000001, 1'b0, 1'b0, 1'b1, 4'd7, 4'sd3, 1'b0, 4'd0, 4'sd0,
        1, 1'b1, 0, N_IN + 2);
    run("same-edge w4", 7'b0010000, 1'b0, 1'b0, 1'b1, 4'd4, 4'sd5, 1'b0, 4'd0, 4'sd0,
        8, 1'b1, 0, N_IN + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
